crc_frame_seq: RTL and testbench



---
 rtl/crc_pkg.sv | 28 ++
 rtl/crc_chunk_pack.sv | 54 +++++
 rtl/crc_frame_seq.sv | 132 +++++++++++++
 tb/tb_crc_frame_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared constants and state type for the CRC-32 frame sequencer and its bench model.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package crc_pkg;

  // Bytes per engine chunk; the engine datapath is fixed at 128 bits.
  localparam int CHUNK_BYTES = 16;

  // CRC-32 seed used by the engine after a clear (reference models use it too).
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  // Cycles to wait for the engine to drop ready after a chunk strobe before
  // assuming it already finished.
  localparam int ENG_TO = 4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CLR       = 4'd1,
    ST_CLR_WAIT  = 4'd2,
    ST_FILL      = 4'd3,
    ST_ISSUE     = 4'd4,
    ST_WAIT_BUSY = 4'd5,
    ST_WAIT_RDY  = 4'd6,
    ST_SETTLE    = 4'd7,
    ST_DONE      = 4'd8
  } crc_seq_state_t;

endpackage

// File: rtl/crc_chunk_pack.sv
// Packs accepted bytes into a 128-bit chunk, byte 0 in the top lane, and reports its length.
// Latency: a written byte appears in o_data the cycle after i_wr; o_done is combinational.
// Backpressure: none; the caller only asserts i_wr when it can take a full/last chunk.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_clr           zero all lanes, the lane index and the length
//   i_wr, i_byte    write i_byte into the current lane and advance the index
//   i_last          the byte being written closes the frame
//   o_data          packed chunk, lane k at [127-8k -: 8], unused lanes zero
//   o_len           valid bytes of the closed chunk, 0 means 16
//   o_done          this write fills lane 15 or carries i_last
module crc_chunk_pack
  import crc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_wr,
  input  logic [7:0]               i_byte,
  input  logic                     i_last,
  output logic [8*CHUNK_BYTES-1:0] o_data,
  output logic [3:0]               o_len,
  output logic                     o_done
);

  logic [8*CHUNK_BYTES-1:0] r_data;
  logic [3:0]               r_lane;
  logic [3:0]               r_len;
  logic                     w_full;

  assign w_full = (r_lane == 4'(CHUNK_BYTES - 1));
  assign o_done = i_wr & (w_full | i_last);
  assign o_data = r_data;
  assign o_len  = r_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_lane <= '0;
      r_len  <= '0;
    end else if (i_clr) begin
      r_data <= '0;
      r_lane <= '0;
      r_len  <= '0;
    end else if (i_wr) begin
      r_data[(CHUNK_BYTES - 1 - int'(r_lane)) * 8 +: 8] <= i_byte;
      r_lane <= r_lane + 4'd1;
      // lane 15 + 1 wraps to 0, which is exactly the "16 bytes" encoding
      if (o_done) r_len <= r_lane + 4'd1;
    end
  end

endmodule

// File: rtl/crc_frame_seq.sv
// Frame sequencer for the shared 16-byte CRC-32 engine: clears it, feeds 128-bit chunks, returns the FCS.
// Latency: last-byte handshake to fcs_valid = ISSUE + engine turnaround + SETTLE + 1 cycle.
// Backpressure: s_ready is high only while filling a chunk; fcs is held in DONE until fcs_ready.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready  input byte stream
//   eng_clr, eng_en                engine clear pulse and chunk strobe
//   eng_data, eng_len              chunk (byte 0 at [127:120]) and length (0 means 16)
//   eng_crc, eng_rdy               engine result and idle/result-valid
//   fcs/fcs_len/fcs_valid/fcs_ready  frame CRC and saturating byte count
module crc_frame_seq
  import crc_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     eng_clr,
  output logic [8*CHUNK_BYTES-1:0] eng_data,
  output logic [3:0]               eng_len,
  output logic                     eng_en,
  input  logic [31:0]              eng_crc,
  input  logic                     eng_rdy,
  output logic [31:0]              fcs,
  output logic [LEN_W-1:0]         fcs_len,
  output logic                     fcs_valid,
  input  logic                     fcs_ready
);

  crc_seq_state_t r_state;
  crc_seq_state_t w_state_nxt;

  logic [2:0]       r_cnt;        // dwell counter for CLR_WAIT and WAIT_BUSY
  logic [LEN_W-1:0] r_byte_cnt;
  logic             r_last_chunk; // s_last of the most recently accepted byte
  logic             r_s_ready;
  logic             r_eng_clr;
  logic             r_eng_en;
  logic [31:0]      r_fcs;
  logic [LEN_W-1:0] r_fcs_len;
  logic             r_fcs_valid;

  logic             w_acc;
  logic             w_chunk_done;
  logic             w_pack_clr;

  // r_s_ready is only high in FILL, so this is the byte handshake
  assign w_acc = s_valid & r_s_ready;

  // Lanes are cleared at frame start and after each non-final chunk is consumed
  assign w_pack_clr = (r_state == ST_CLR) ||
                      (r_state == ST_WAIT_RDY && eng_rdy && !r_last_chunk);

  crc_chunk_pack u_pack (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_pack_clr),
    .i_wr   (w_acc),
    .i_byte (s_data),
    .i_last (s_last),
    .o_data (eng_data),
    .o_len  (eng_len),
    .o_done (w_chunk_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (s_valid) w_state_nxt = ST_CLR;
      ST_CLR:       w_state_nxt = ST_CLR_WAIT;
      ST_CLR_WAIT:  if (r_cnt == 3'd1) w_state_nxt = ST_FILL;
      ST_FILL:      if (w_chunk_done) w_state_nxt = ST_ISSUE;
      ST_ISSUE:     w_state_nxt = ST_WAIT_BUSY;
      // An engine that never drops ready within the window is taken as done
      ST_WAIT_BUSY: if (!eng_rdy || r_cnt == 3'(ENG_TO - 1)) w_state_nxt = ST_WAIT_RDY;
      ST_WAIT_RDY:  if (eng_rdy) w_state_nxt = r_last_chunk ? ST_SETTLE : ST_FILL;
      ST_SETTLE:    w_state_nxt = ST_DONE;
      ST_DONE:      if (fcs_ready) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and s_ready are registered from the next state so they line up
  // with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_s_ready    <= 1'b0;
      r_eng_clr    <= 1'b0;
      r_eng_en     <= 1'b0;
      r_fcs_valid  <= 1'b0;
      r_byte_cnt   <= '0;
      r_last_chunk <= 1'b0;
      r_fcs        <= '0;
      r_fcs_len    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= (w_state_nxt != r_state) ? 3'd0 : r_cnt + 3'd1;
      r_s_ready   <= (w_state_nxt == ST_FILL);
      r_eng_clr   <= (w_state_nxt == ST_CLR);
      r_eng_en    <= (w_state_nxt == ST_ISSUE);
      r_fcs_valid <= (w_state_nxt == ST_DONE);

      if (r_state == ST_CLR) begin
        r_byte_cnt   <= '0;
        r_last_chunk <= 1'b0;
      end else if (w_acc) begin
        r_last_chunk <= s_last;
        if (r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 1'b1;
      end

      if (r_state == ST_SETTLE) begin
        r_fcs     <= eng_crc;
        r_fcs_len <= r_byte_cnt;
      end
    end
  end

  assign s_ready   = r_s_ready;
  assign eng_clr   = r_eng_clr;
  assign eng_en    = r_eng_en;
  assign fcs       = r_fcs;
  assign fcs_len   = r_fcs_len;
  assign fcs_valid = r_fcs_valid;

endmodule

// File: tb/tb_crc_frame_seq.sv
// Directed and randomized-gap bench for crc_frame_seq with a behavioural CRC_16B engine.
// Latency: n/a.
// Backpressure: n/a.
module tb_crc_frame_seq;
  import crc_pkg::*;

  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          eng_clr;
  logic [127:0]  eng_data;
  logic [3:0]    eng_len;
  logic          eng_en;
  logic [31:0]   eng_crc = '0;
  logic          eng_rdy = 1'b1;
  logic [31:0]   fcs;
  logic [LW-1:0] fcs_len;
  logic          fcs_valid;
  logic          fcs_ready = 1'b0;

  int total = 0;
  int bad = 0;

  logic [7:0] fbytes [0:511];
  int         flen = 0;
  bit         keep_rdy = 1'b0;

  crc_frame_seq #(.LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .eng_clr(eng_clr), .eng_data(eng_data), .eng_len(eng_len), .eng_en(eng_en),
    .eng_crc(eng_crc), .eng_rdy(eng_rdy),
    .fcs(fcs), .fcs_len(fcs_len), .fcs_valid(fcs_valid), .fcs_ready(fcs_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    c = CRC_INIT;
    for (int i = 0; i < n; i++) c = crc_byte(c, fbytes[i]);
    return ~c;
  endfunction

  // Engine model: registered clear, busy for 2..5 cycles per chunk, or
  // (e_skip) answers at once without ever dropping ready.
  logic [31:0]  e_state = CRC_INIT;
  logic [127:0] e_chunk;
  int           e_busy = 0;
  int           e_n;
  bit           e_skip = 1'b0;
  always begin
    @(posedge clk); #1;
    if (eng_clr) e_state = CRC_INIT;
    if (eng_en) begin
      e_chunk = eng_data;
      e_n = (eng_len == 4'd0) ? 16 : int'(eng_len);
      for (int b = 0; b < e_n; b++) e_state = crc_byte(e_state, e_chunk[127 - 8*b -: 8]);
      if (e_skip) eng_crc = ~e_state;
      else begin
        eng_rdy = 1'b0;
        e_busy = $urandom_range(5, 2);
      end
    end else if (e_busy > 0) begin
      e_busy--;
      if (e_busy == 0) begin
        eng_crc = ~e_state;
        eng_rdy = 1'b1;
      end
    end
  end

  // Engine-side monitor
  int           clr_cnt = 0;
  int           en_cnt = 0;
  logic [3:0]   len_q [$];
  logic [127:0] dat_q [$];
  always @(negedge clk) begin
    if (eng_clr) clr_cnt++;
    if (eng_en) begin
      en_cnt++;
      len_q.push_back(eng_len);
      dat_q.push_back(eng_data);
    end
  end

  task automatic load_123;
    logic [71:0] s;
    s = 72'h313233343536373839;
    for (int i = 0; i < 9; i++) fbytes[i] = s[71 - 8*i -: 8];
    flen = 9;
  endtask

  // Sends bytes 0..n_send-1 of fbytes; s_last only on byte flen-1.
  task automatic drive_frame(input int n_send, input bit gaps, output bit tmo);
    bit got;
    tmo = 1'b0;
    for (int i = 0; i < n_send && !tmo; i++) begin
      if (gaps && $urandom_range(1, 0) == 1) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = fbytes[i];
      s_last  = (i == flen - 1);
      got = 1'b0;
      for (int w = 0; w < 50 && !got; w++) begin
        @(negedge clk);
        got = s_ready;
      end
      if (got) begin
        @(posedge clk); #1;
      end else tmo = 1'b1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_fcs(output bit tmo);
    tmo = 1'b1;
    for (int w = 0; w < 100 && tmo; w++) begin
      @(negedge clk);
      if (fcs_valid) tmo = 1'b0;
    end
  endtask

  task automatic ack_fcs;
    fcs_ready = 1'b1;
    @(posedge clk); #1;
    fcs_ready = keep_rdy;
  endtask

  task automatic run_frame(input int n, input bit gaps, output bit tmo,
                           output logic [31:0] f, output logic [LW-1:0] l,
                           output int dc, output int de);
    int c0, e0;
    c0 = clr_cnt;
    e0 = en_cnt;
    drive_frame(n, gaps, tmo);
    if (!tmo) wait_fcs(tmo);
    f = fcs;
    l = fcs_len;
    if (!tmo) ack_fcs();
    dc = clr_cnt - c0;
    de = en_cnt - e0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #12;
    total++;
    if ({s_ready, eng_clr, eng_en, eng_len, eng_data, fcs, fcs_len, fcs_valid} !== '0) begin
      bad++;
      $display("FAIL reset_in: outputs=%h expected all zero",
               {s_ready, eng_clr, eng_en, eng_len, eng_data, fcs, fcs_len, fcs_valid});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({s_ready, eng_clr, eng_en, eng_len, eng_data, fcs, fcs_len, fcs_valid} !== '0) begin
      bad++;
      $display("FAIL reset_idle: outputs=%h expected all zero",
               {s_ready, eng_clr, eng_en, eng_len, eng_data, fcs, fcs_len, fcs_valid});
    end
  endtask

  task automatic test_123;
    bit tmo; logic [31:0] f; logic [LW-1:0] l; int dc, de, q0;
    load_123();
    q0 = len_q.size();
    run_frame(9, 1'b0, tmo, f, l, dc, de);
    total++; if (tmo) begin bad++; $display("FAIL s123_timeout: no fcs_valid"); end
    total++; if (f !== 32'hCBF43926) begin bad++; $display("FAIL s123_fcs: got %h want cbf43926", f); end
    total++; if (l !== LW'(9)) begin bad++; $display("FAIL s123_len: got %0d want 9", l); end
    total++; if (dc != 1 || de != 1) begin bad++; $display("FAIL s123_counts: clr=%0d en=%0d want 1/1", dc, de); end
    total++;
    if (len_q.size() != q0 + 1) begin bad++; $display("FAIL s123_chunks: got %0d want 1", len_q.size() - q0); end
    else if (len_q[q0] !== 4'd9 || dat_q[q0] !== {72'h313233343536373839, 56'h0}) begin
      bad++; $display("FAIL s123_chunk: len=%0d data=%h want 9 / 313233343536373839 then zeros", len_q[q0], dat_q[q0]);
    end
  endtask

  task automatic test_zero16;
    bit tmo; logic [31:0] f; logic [LW-1:0] l; int dc, de, q0;
    for (int i = 0; i < 16; i++) fbytes[i] = 8'h00;
    flen = 16;
    q0 = len_q.size();
    run_frame(16, 1'b0, tmo, f, l, dc, de);
    total++; if (tmo) begin bad++; $display("FAIL z16_timeout: no fcs_valid"); end
    total++; if (f !== 32'hECBB4B55) begin bad++; $display("FAIL z16_fcs: got %h want ecbb4b55", f); end
    total++; if (f !== ref_crc(16)) begin bad++; $display("FAIL z16_model: got %h want %h", f, ref_crc(16)); end
    total++; if (l !== LW'(16)) begin bad++; $display("FAIL z16_len: got %0d want 16", l); end
    total++;
    if (de != 1 || len_q.size() != q0 + 1) begin bad++; $display("FAIL z16_chunks: got %0d want 1", de); end
    else if (len_q[q0] !== 4'd0) begin bad++; $display("FAIL z16_eng_len: got %0d want 0", len_q[q0]); end
  endtask

  task automatic test_33;
    bit tmo; logic [31:0] f; logic [LW-1:0] l; int dc, de, q0;
    for (int i = 0; i < 33; i++) fbytes[i] = 8'(i);
    flen = 33;
    q0 = len_q.size();
    run_frame(33, 1'b0, tmo, f, l, dc, de);
    total++; if (tmo) begin bad++; $display("FAIL a33_timeout: no fcs_valid"); end
    total++; if (f !== ref_crc(33)) begin bad++; $display("FAIL a33_fcs: got %h want %h", f, ref_crc(33)); end
    total++; if (l !== LW'(33)) begin bad++; $display("FAIL a33_len: got %0d want 33", l); end
    total++;
    if (len_q.size() != q0 + 3) begin bad++; $display("FAIL a33_chunks: got %0d want 3", len_q.size() - q0); end
    else if ({len_q[q0], len_q[q0+1], len_q[q0+2]} !== 12'h001 || dat_q[q0+2] !== {8'h20, 120'h0}) begin
      bad++; $display("FAIL a33_lens: got %h/%h want 001 and 20 then zeros",
                      {len_q[q0], len_q[q0+1], len_q[q0+2]}, dat_q[q0+2]);
    end
  endtask

  task automatic test_hold;
    bit tmo; int c0;
    load_123();
    drive_frame(9, 1'b0, tmo);
    if (!tmo) wait_fcs(tmo);
    total++; if (tmo) begin bad++; $display("FAIL hold_timeout: no fcs_valid"); end
    c0 = clr_cnt;
    s_valid = 1'b1;
    s_data  = fbytes[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({fcs_valid, s_ready, fcs} !== {1'b1, 1'b0, 32'hCBF43926}) begin
        bad++; $display("FAIL hold_stable: valid/ready/fcs=%b/%b/%h want 1/0/cbf43926", fcs_valid, s_ready, fcs);
      end
    end
    total++; if (clr_cnt != c0) begin bad++; $display("FAIL hold_noclr: %0d clears want 0", clr_cnt - c0); end
    ack_fcs();
    for (int w = 0; w < 6 && clr_cnt == c0; w++) @(negedge clk);
    total++; if (clr_cnt - c0 != 1) begin bad++; $display("FAIL hold_next_clr: %0d clears want 1", clr_cnt - c0); end
    drive_frame(9, 1'b0, tmo);
    if (!tmo) wait_fcs(tmo);
    total++; if (tmo || fcs !== 32'hCBF43926) begin bad++; $display("FAIL hold_next_fcs: got %h want cbf43926", fcs); end
    if (!tmo) ack_fcs();
  endtask

  task automatic test_reset_mid;
    bit tmo; logic [31:0] f; logic [LW-1:0] l; int dc, de;
    load_123();
    drive_frame(7, 1'b0, tmo);
    total++; if (tmo) begin bad++; $display("FAIL rmid_timeout: 7 bytes not accepted"); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({s_ready, eng_clr, eng_en, eng_len, eng_data, fcs, fcs_len, fcs_valid} !== '0) begin
      bad++; $display("FAIL rmid_outputs: got %h want all zero",
                      {s_ready, eng_clr, eng_en, eng_len, eng_data, fcs, fcs_len, fcs_valid});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(9, 1'b0, tmo, f, l, dc, de);
    total++; if (tmo || f !== 32'hCBF43926) begin bad++; $display("FAIL rmid_fcs: got %h want cbf43926", f); end
    total++; if (l !== LW'(9) || dc != 1) begin bad++; $display("FAIL rmid_len: len=%0d clr=%0d want 9/1", l, dc); end
  endtask

  task automatic test_timeout;
    bit tmo; logic [31:0] f; logic [LW-1:0] l; int dc, de;
    e_skip = 1'b1;
    for (int i = 0; i < 20; i++) fbytes[i] = 8'(8'hA0 + i);
    flen = 20;
    run_frame(20, 1'b0, tmo, f, l, dc, de);
    e_skip = 1'b0;
    total++; if (tmo || f !== ref_crc(20)) begin bad++; $display("FAIL to_fcs: got %h want %h", f, ref_crc(20)); end
    total++; if (l !== LW'(20) || de != 2) begin bad++; $display("FAIL to_len: len=%0d en=%0d want 20/2", l, de); end
  endtask

  task automatic test_saturate;
    bit tmo; logic [31:0] f; logic [LW-1:0] l; int dc, de;
    for (int i = 0; i < 300; i++) fbytes[i] = 8'(i * 7);
    flen = 300;
    run_frame(300, 1'b0, tmo, f, l, dc, de);
    total++; if (tmo || f !== ref_crc(300)) begin bad++; $display("FAIL sat_fcs: got %h want %h", f, ref_crc(300)); end
    total++; if (l !== {LW{1'b1}}) begin bad++; $display("FAIL sat_len: got %0d want %0d", l, {LW{1'b1}}); end
    total++; if (de != 19) begin bad++; $display("FAIL sat_chunks: got %0d want 19", de); end
  endtask

  task automatic test_random;
    bit tmo; logic [31:0] f; logic [LW-1:0] l; int dc, de, n;
    keep_rdy  = 1'b1;
    fcs_ready = 1'b1;
    for (int fr = 0; fr < 100; fr++) begin
      n = $urandom_range(200, 1);
      for (int i = 0; i < n; i++) fbytes[i] = 8'($urandom);
      flen = n;
      run_frame(n, 1'b1, tmo, f, l, dc, de);
      total++; if (tmo) begin bad++; $display("FAIL rnd_timeout: frame %0d len %0d", fr, n); end
      total++; if (f !== ref_crc(n)) begin bad++; $display("FAIL rnd_fcs: frame %0d got %h want %h", fr, f, ref_crc(n)); end
      total++; if (l !== LW'(n)) begin bad++; $display("FAIL rnd_len: frame %0d got %0d want %0d", fr, l, n); end
      total++; if (dc != 1) begin bad++; $display("FAIL rnd_clr: frame %0d got %0d want 1", fr, dc); end
      total++; if (de != (n + 15) / 16) begin bad++; $display("FAIL rnd_en: frame %0d got %0d want %0d", fr, de, (n + 15) / 16); end
    end
    keep_rdy  = 1'b0;
    fcs_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_123();
    test_zero16();
    test_33();
    test_hold();
    test_reset_mid();
    test_timeout();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
